posit_mul_issuer: RTL and testbench
===================================

// Module: posit_mul_issuer
// PURPOSE
//  Operand front-end for posit_mul (32-bit posit, ES=3). Buffers operand pairs in a small FIFO (valid/ready in).
//  Issues one pair at a time to the multiplier with a single-cycle start pulse and waits for its done.
//  Holds each result in an output register (valid/ready out). A cycle watchdog converts a hung op into NaR.
// PARAMETERS
//  DEPTH    4    operand FIFO entries; power of 2, >=2
//  TIMEOUT  255  max WAIT cycles before watchdog fires; 1..65535
// PORTS
//  clk         in   1   clock
//  rst_n       in   1   asynchronous, active-low reset
//  in_valid    in   1   operand pair valid
//  in_ready    out  1   FIFO not full
//  in_a        in   32  posit operand A
//  in_b        in   32  posit operand B
//  mul_start   out  1   one-cycle start pulse to posit_mul
//  mul_a       out  32  operand A to posit_mul; registered, stable from ISSUE until the op retires
//  mul_b       out  32  operand B to posit_mul; same timing as mul_a
//  mul_result  in   32  posit_mul result
//  mul_done    in   1   posit_mul done; may stay high between ops
//  mul_nar     in   1   posit_mul NAR flag
//  mul_zero    in   1   posit_mul ZERO flag
//  out_valid   out  1   result register holds an unconsumed result
//  out_ready   in   1   consumer accepts the result
//  out_result  out  32  result posit
//  out_nar     out  1   result is NaR (0x80000000)
//  out_zero    out  1   result is zero
//  out_timeout out  1   result was produced by the watchdog
//  occupancy   out  clog2(DEPTH)+1  FIFO entry count
// BEHAVIOUR
//  Reset: FIFO empty (occupancy=0), in_ready=1, FSM=IDLE, watchdog=0, mul_start=0, mul_a=mul_b=0,
//   out_valid=0, out_result=0, out_nar=out_zero=out_timeout=0. Reset mid-op discards FIFO and in-flight op.
//  FIFO: push when in_valid&in_ready. Pop only when an op retires. Pointers are clog2(DEPTH)+1 bits
//   with a wrap bit. in_ready = !full, taken from current occupancy. A pop in the same cycle does not admit a
//   push into a full FIFO. Push and pop together: occupancy unchanged.
//  Edge detect: done_q <= mul_done every cycle. done_rise = mul_done & ~done_q.
//   Only done_rise is honoured, and only in WAIT.
//  FSM:
//   IDLE  -> ISSUE when occupancy!=0.
//   ISSUE (1 cycle): latch FIFO head into mul_a/mul_b; mul_start=1 on the next cycle (registered pulse);
//         clear watchdog; -> WAIT.
//   WAIT: watchdog++ each cycle.
//     On done_rise: out_result<=mul_result, out_nar<=mul_nar, out_zero<=mul_zero, out_timeout<=0;
//       pop; out_valid<=1; -> HOLD.
//     Else if watchdog==TIMEOUT-1: out_result<=0x80000000, out_nar<=1, out_zero<=0, out_timeout<=1;
//       pop; out_valid<=1; -> HOLD.
//     If done_rise and the watchdog fire occur in the same cycle, done_rise wins.
//   HOLD: when out_ready, out_valid<=0, then -> ISSUE if occupancy!=0 (after the pop), else -> IDLE.
//     out_* stay stable while out_valid=1.
//  Throughput: one op in flight. Back-to-back ops have 2 cycles of overhead (HOLD->ISSUE->start).
//  mul_done edges outside WAIT are ignored.
// CONFIGURATION
//  POSIT_ISSUER_BYPASS_EN defined:
//   - In ISSUE, if either head operand is 0x80000000: retire with out_result=0x80000000, out_nar=1.
//   - Else if either head operand is 0x00000000: retire with out_result=0, out_zero=1.
//   - Either case: pop, -> HOLD next cycle, no mul_start, out_timeout=0.
//   - NaR takes priority over zero.
//  Not defined: every pair goes through posit_mul.
// TESTING (stub multiplier: done rises N cycles after start, level-high until next start)
//  1. Push (0x40000000,0x40000000), stub N=5 returns 0x40000000 -> one mul_start pulse;
//     out_valid 1 cycle after done_rise; out_result=0x40000000, out_nar=out_zero=out_timeout=0.
//  2. out_ready=0; push DEPTH+1 pairs -> in_ready=0 at occupancy=DEPTH; extra pair not accepted;
//     results emerge in push order once out_ready=1.
//  3. Stub never asserts done, TIMEOUT=8 -> out_valid 8 cycles after WAIT entry; out_result=0x80000000,
//     out_nar=1, out_timeout=1; next pair then issues normally.
//  4. Stub done held high across ops -> second op retires only on the new rising edge, never on stale high.
//  5. Assert rst_n=0 mid-WAIT with 3 entries queued -> all outputs return to reset values;
//     a late mul_done is ignored; occupancy=0.
//  6. BYPASS_EN: push (0x80000000,0x00000000) -> no mul_start, out_result=0x80000000, out_nar=1;
//     push (0,0x40000000) -> out_result=0, out_zero=1. Without the macro, both pairs are issued to the stub.

Source files
------------

// File: rtl/posit_mul_issuer.sv
// rtl/posit_mul_issuer.sv - operand FIFO and issue/retire front-end for posit_mul
//
// Purpose:
//   Buffers posit operand pairs in a small FIFO, issues one pair at a time to
//   posit_mul with a registered single-cycle start pulse, waits for the rising
//   edge of mul_done, and holds the result in an output register until the
//   consumer accepts it. A cycle watchdog retires a hung op as NaR.
//
// Optional feature (macro POSIT_ISSUER_BYPASS_EN):
//   When defined, pairs with a NaR or zero operand retire directly from ISSUE
//   without touching the multiplier (NaR has priority over zero).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          operand pair handshake (in_ready = FIFO not full)
//   in_a, in_b                 32-bit posit operands
//   mul_start                  one-cycle start pulse to posit_mul
//   mul_a, mul_b               registered operands, stable while the op is live
//   mul_result/done/nar/zero   posit_mul response (done may stay high)
//   out_valid/out_ready        result handshake
//   out_result/nar/zero        result posit and its flags
//   out_timeout                result was produced by the watchdog
//   occupancy                  FIFO entry count
module posit_mul_issuer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  output logic                     mul_start,
  output logic [31:0]              mul_a,
  output logic [31:0]              mul_b,
  input  logic [31:0]              mul_result,
  input  logic                     mul_done,
  input  logic                     mul_nar,
  input  logic                     mul_zero,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic                     out_nar,
  output logic                     out_zero,
  output logic                     out_timeout,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          PW      = AW + 1;
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
  localparam logic [31:0] NAR     = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [63:0]   mem_q [DEPTH];
  logic [63:0]   mem_d [DEPTH];
  logic [15:0]   watchdog_q, watchdog_d;
  logic          done_q, done_d;
  logic          mul_start_q, mul_start_d;
  logic [31:0]   mul_a_q, mul_a_d;
  logic [31:0]   mul_b_q, mul_b_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_result_q, out_result_d;
  logic          out_nar_q, out_nar_d;
  logic          out_zero_q, out_zero_d;
  logic          out_timeout_q, out_timeout_d;

  logic [PW-1:0] occ;
  logic          full;
  logic          push;
  logic          pop;
  logic          done_rise;
  logic [31:0]   head_a;
  logic [31:0]   head_b;

  // Wrap-bit pointers: the difference is the exact entry count.
  assign occ       = wr_ptr_q - rd_ptr_q;
  assign full      = (occ == FULL_CNT);
  // in_ready depends only on registered occupancy, so a same-cycle pop
  // never lets a push into a full FIFO.
  assign push      = in_valid & ~full;
  assign done_rise = mul_done & ~done_q;
  assign head_a    = mem_q[rd_ptr_q[AW-1:0]][63:32];
  assign head_b    = mem_q[rd_ptr_q[AW-1:0]][31:0];

  always_comb begin
    state_d       = state_q;
    watchdog_d    = watchdog_q;
    mul_start_d   = 1'b0;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_nar_d     = out_nar_q;
    out_zero_d    = out_zero_q;
    out_timeout_d = out_timeout_q;
    pop           = 1'b0;
    // mul_done is tracked every cycle so a level left high from a previous
    // op never looks like a fresh edge when WAIT is entered.
    done_d        = mul_done;

    case (state_q)
      S_IDLE: begin
        if (occ != '0) state_d = S_ISSUE;
      end

      S_ISSUE: begin
        mul_a_d    = head_a;
        mul_b_d    = head_b;
        watchdog_d = '0;
`ifdef POSIT_ISSUER_BYPASS_EN
        if (head_a == NAR || head_b == NAR) begin
          out_result_d  = NAR;
          out_nar_d     = 1'b1;
          out_zero_d    = 1'b0;
          out_timeout_d = 1'b0;
          out_valid_d   = 1'b1;
          pop           = 1'b1;
          state_d       = S_HOLD;
        end else if (head_a == 32'h0 || head_b == 32'h0) begin
          out_result_d  = 32'h0;
          out_nar_d     = 1'b0;
          out_zero_d    = 1'b1;
          out_timeout_d = 1'b0;
          out_valid_d   = 1'b1;
          pop           = 1'b1;
          state_d       = S_HOLD;
        end else begin
          mul_start_d = 1'b1;
          state_d     = S_WAIT;
        end
`else
        mul_start_d = 1'b1;
        state_d     = S_WAIT;
`endif
      end

      S_WAIT: begin
        watchdog_d = watchdog_q + 16'd1;
        // A real completion beats the watchdog when both land together.
        if (done_rise) begin
          out_result_d  = mul_result;
          out_nar_d     = mul_nar;
          out_zero_d    = mul_zero;
          out_timeout_d = 1'b0;
          out_valid_d   = 1'b1;
          pop           = 1'b1;
          state_d       = S_HOLD;
        end else if (watchdog_q == WD_LAST) begin
          out_result_d  = NAR;
          out_nar_d     = 1'b1;
          out_zero_d    = 1'b0;
          out_timeout_d = 1'b1;
          out_valid_d   = 1'b1;
          pop           = 1'b1;
          state_d       = S_HOLD;
        end
      end

      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = (occ != '0) ? S_ISSUE : S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q[AW-1:0]] = {in_a, in_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      watchdog_q    <= '0;
      done_q        <= 1'b0;
      mul_start_q   <= 1'b0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_nar_q     <= 1'b0;
      out_zero_q    <= 1'b0;
      out_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_q         <= mem_d;
      watchdog_q    <= watchdog_d;
      done_q        <= done_d;
      mul_start_q   <= mul_start_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_nar_q     <= out_nar_d;
      out_zero_q    <= out_zero_d;
      out_timeout_q <= out_timeout_d;
    end
  end

  assign in_ready    = ~full;
  assign occupancy   = occ;
  assign mul_start   = mul_start_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_nar     = out_nar_q;
  assign out_zero    = out_zero_q;
  assign out_timeout = out_timeout_q;

endmodule

// File: tb/tb_posit_mul_issuer.sv
// tb/tb_posit_mul_issuer.sv - directed self-checking bench for posit_mul_issuer
module tb_posit_mul_issuer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        mul_start;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [31:0] mul_result;
  logic        mul_done;
  logic        mul_nar;
  logic        mul_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_nar;
  logic        out_zero;
  logic        out_timeout;
  logic [2:0]  occupancy;

  int vectors;
  int miscompares;

  // Stub multiplier: result = operand A; done rises stub_n cycles after start.
  int          stub_n;
  logic        stub_hang;
  logic        stub_sticky;
  logic        force_done;
  int          stub_cnt;
  logic        stub_done;
  logic [31:0] stub_res;
  int          start_cnt;

  posit_mul_issuer #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .mul_done(mul_done), .mul_nar(mul_nar), .mul_zero(mul_zero),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_nar(out_nar), .out_zero(out_zero), .out_timeout(out_timeout),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_cnt  <= 0;
      stub_done <= 1'b0;
      stub_res  <= 32'h0;
    end else if (mul_start) begin
      stub_res <= mul_a;
      stub_cnt <= stub_hang ? 0 : stub_n;
      if (!stub_sticky) stub_done <= 1'b0;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 2 && stub_sticky) stub_done <= 1'b0;
      if (stub_cnt == 1) stub_done <= 1'b1;
    end
  end

  assign mul_result = stub_res;
  assign mul_done   = stub_done | force_done;
  assign mul_nar    = (stub_res == 32'h8000_0000);
  assign mul_zero   = (stub_res == 32'h0);

  initial start_cnt = 0;
  always @(posedge clk) if (mul_start) start_cnt <= start_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int n;
    logic done;
    in_valid = 1'b1; in_a = a; in_b = b;
    n = 0; done = 1'b0;
    while (!done && n < 300) begin
      if (in_ready) done = 1'b1;
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check1("push_accepted", done, 1'b1);
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (!mul_start && n < 300) begin @(negedge clk); n++; end
    check1({tag, "_start_seen"}, mul_start, 1'b1);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 300) begin @(negedge clk); n++; end
    check1({tag, "_valid_seen"}, out_valid, 1'b1);
  endtask

  // Cycles from the visible start pulse to the visible out_valid.
  task automatic measure(input string tag, output int lat);
    logic seen;
    wait_start(tag);
    lat = 0; seen = 1'b0;
    while (!seen && lat < 300) begin
      @(negedge clk);
      lat++;
      if (out_valid) seen = 1'b1;
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] r,
                              input logic nar, input logic zero, input logic to);
    check({tag, "_result"}, out_result, r);
    check1({tag, "_nar"}, out_nar, nar);
    check1({tag, "_zero"}, out_zero, zero);
    check1({tag, "_timeout"}, out_timeout, to);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int s0;
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    stub_n = 5; stub_hang = 1'b0; stub_sticky = 1'b0; force_done = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_mul_start", mul_start, 1'b0);
    check("rst_mul_a", mul_a, 32'h0);
    check("rst_mul_b", mul_b, 32'h0);
    check1("rst_out_valid", out_valid, 1'b0);
    check_result("rst", 32'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single op, N=5
    s0 = start_cnt;
    push(32'h4000_0000, 32'h4000_0000);
    measure("t1", lat);
    check("t1_latency", 32'(lat), 32'd7);
    check("t1_mul_a", mul_a, 32'h4000_0000);
    check("t1_mul_b", mul_b, 32'h4000_0000);
    check_result("t1", 32'h4000_0000, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check1("t1_hold_valid", out_valid, 1'b1);
    check("t1_hold_result", out_result, 32'h4000_0000);
    check("t1_start_count", 32'(start_cnt - s0), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check1("t1_consumed", out_valid, 1'b0);
    out_ready = 1'b0;

    // 2: fill FIFO with consumer stalled, results in order
    for (int i = 1; i <= 4; i++) push(32'(32'h1111_1111 * i), 32'h4000_0000);
    check("t2_occ_full", 32'(occupancy), 32'd4);
    check1("t2_in_ready_full", in_ready, 1'b0);
    in_valid = 1'b1; in_a = 32'h5555_5555; in_b = 32'h4000_0000;
    @(negedge clk);
    in_valid = 1'b0;
    check("t2_extra_rejected", 32'(occupancy), 32'd4);
    push(32'h5555_5555, 32'h4000_0000);
    check("t2_occ_after_pop_push", 32'(occupancy), 32'd4);
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wait_valid("t2");
      check_result("t2_order", 32'(32'h1111_1111 * i), 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("t2_occ_drained", 32'(occupancy), 32'd0);

    // 3: hung multiplier -> watchdog NaR, then normal op
    stub_hang = 1'b1;
    push(32'h4000_0000, 32'h4800_0000);
    measure("t3", lat);
    check("t3_latency", 32'(lat), 32'd8);
    check_result("t3", 32'h8000_0000, 1'b1, 1'b0, 1'b1);
    stub_hang = 1'b0;
    @(negedge clk);
    push(32'h3C00_0000, 32'h4000_0000);
    measure("t3b", lat);
    check("t3b_latency", 32'(lat), 32'd7);
    check_result("t3b", 32'h3C00_0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // 4: done left high across ops; only a fresh rising edge retires
    stub_sticky = 1'b1;
    check1("t4_done_stale_high", mul_done, 1'b1);
    push(32'h4400_0000, 32'h4000_0000);
    measure("t4a", lat);
    check("t4a_latency", 32'(lat), 32'd7);
    check_result("t4a", 32'h4400_0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    push(32'h4800_0000, 32'h4000_0000);
    measure("t4b", lat);
    check("t4b_latency", 32'(lat), 32'd7);
    check_result("t4b", 32'h4800_0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    stub_sticky = 1'b0;

    // 5: reset mid-WAIT with three entries queued
    stub_hang = 1'b1;
    push(32'h1234_5678, 32'h4000_0000);
    push(32'h2345_6789, 32'h4000_0000);
    push(32'h3456_789A, 32'h4000_0000);
    wait_start("t5");
    check("t5_occ_before", 32'(occupancy), 32'd3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_occ_rst", 32'(occupancy), 32'd0);
    check1("t5_in_ready_rst", in_ready, 1'b1);
    check("t5_mul_a_rst", mul_a, 32'h0);
    check("t5_mul_b_rst", mul_b, 32'h0);
    check1("t5_mul_start_rst", mul_start, 1'b0);
    check1("t5_out_valid_rst", out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    stub_hang = 1'b0;
    s0 = start_cnt;
    @(negedge clk);
    force_done = 1'b1;
    repeat (3) @(negedge clk);
    force_done = 1'b0;
    repeat (5) @(negedge clk);
    check1("t5_late_done_ignored", out_valid, 1'b0);
    check("t5_occ_after", 32'(occupancy), 32'd0);
    check("t5_no_start", 32'(start_cnt - s0), 32'd0);

    // 6: NaR / zero operand pairs
    stub_n = 3;
    s0 = start_cnt;
    push(32'h8000_0000, 32'h0000_0000);
    wait_valid("t6a");
    check_result("t6a", 32'h8000_0000, 1'b1, 1'b0, 1'b0);
`ifdef POSIT_ISSUER_BYPASS_EN
    check("t6a_starts", 32'(start_cnt - s0), 32'd0);
`else
    check("t6a_starts", 32'(start_cnt - s0), 32'd1);
`endif
    @(negedge clk);
    s0 = start_cnt;
    push(32'h0000_0000, 32'h4000_0000);
    wait_valid("t6b");
    check_result("t6b", 32'h0000_0000, 1'b0, 1'b1, 1'b0);
`ifdef POSIT_ISSUER_BYPASS_EN
    check("t6b_starts", 32'(start_cnt - s0), 32'd0);
`else
    check("t6b_starts", 32'(start_cnt - s0), 32'd1);
`endif
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
